triangle_channel_gen: RTL
=========================

# triangle_channel_gen

Parametrised NES-style triangle-wave channel. It has a CPU-style register write port, frame-sequencer quarter/half-frame strobes and a status-register enable input. It contains the linear counter, the length counter with lookup table, the period timer and the up/down step sequencer, and feeds the mixer with a `SEQ_BITS`-wide wave sample. This generation adds a synchronous reset, a generalised sequence depth and timer width, explicit frame strobes, ultrasonic muting and a `length_active` status output.

## Interface
- `TIMER_WIDTH`, 11, timer period width; legal range 9..11.
- `SEQ_BITS`, 4, wave output width; the sequence has 2^(SEQ_BITS+1) steps.
- `LINEAR_WIDTH`, 7, linear counter / reload value width; legal range 1..7.
- `ULTRASONIC_MIN`, 2, periods below this halt the sequencer.
- `clk` in 1: channel clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `reg_write` in 1: register write strobe, one cycle.
- `reg_addr` in 2: 0 = linear control, 1 = unused, 2 = timer low, 3 = length/timer high.
- `reg_data` in 8: write data.
- `quarter_frame` in 1: one-cycle quarter-frame strobe.
- `half_frame` in 1: one-cycle half-frame strobe.
- `enable` in 1: length-counter enable (status bit).
- `wave` out SEQ_BITS: current sample.
- `length_active` out 1: high when the length counter is not 0.

## Operation
- **Registers.**
  - addr 0: `control` <= data[7]; `reload_val` <= data[LINEAR_WIDTH-1:0].
  - addr 2: `period[7:0]` <= data.
  - addr 3: `period[TIMER_WIDTH-1:8]` <= data[TIMER_WIDTH-9:0]; sets `reload_flag`; reloads `timer_cnt` <= new period. If `enable`=1, it also loads `length` <= LUT[data[7:3]].
- **Length LUT, indices 0..31:** 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30. `length` is 8 bits.
- **Timer.** When `timer_cnt`=0, reload it with `period` and issue a step tick; otherwise decrement it. The timer runs every cycle regardless of the gates.
- **Sequencer gating.** The step index (SEQ_BITS+1 bits) advances on a tick only if all of the following hold:
  - `linear` != 0
  - `length` != 0
  - `period` >= ULTRASONIC_MIN

  If any condition fails, the index and `wave` hold their value. The output is never forced to 0.
- **Wave mapping.** With M = 2^SEQ_BITS − 1:
  - step s < 2^SEQ_BITS: wave = M − s.
  - otherwise: wave = s − 2^SEQ_BITS.

  For the defaults this gives 15..0, then 0..15. The index wraps from the last step to 0, so the sample goes 15 → 15 across the wrap.
- **Linear counter**, on `quarter_frame`:
  - if `reload_flag`=1, `linear` <= `reload_val`; otherwise, if `linear` != 0, decrement it.
  - then, if `control`=0, clear `reload_flag`.
- **Length counter**, on `half_frame`: if `control`=0 and `length` != 0, decrement it. `control`=1 halts it.
- **Enable.** When `enable`=0, `length` is forced to 0 every cycle and writes to addr 3 do not load it.
- **Simultaneous events.**
  - addr-3 write and `half_frame` in the same cycle: the load wins and no decrement is applied.
  - addr-3 write and `quarter_frame` in the same cycle: the quarter-frame update uses the pre-write `reload_flag`, and the flag ends the cycle set.
  - addr-0 write and a strobe in the same cycle: the strobe uses the old `control` and `reload_val`.

## Timing
- **Reset** (wins over all other inputs):
  - `period`, `timer_cnt`, step index, `linear`, `length`, `control`, `reload_val` and `reload_flag` all go to 0.
  - `wave` = M (15 for defaults); `length_active` = 0.
- **Outputs** are registered. `wave` changes on the same edge as the step tick, i.e. period+1 cycles apart. `length_active` updates on the edge after `length` changes.
- **Reset mid-operation** returns all outputs to their reset values on the next edge. Strobes and writes asserted in that cycle are ignored.
- **Register writes** take effect on the write edge; the first tick after an addr-3 write occurs period+1 edges later.

## Test plan
- **Reset:** assert `reset` 1 cycle → `wave`=15, `length_active`=0; strobes and writes during reset have no effect.
- **Basic tone:** `enable`=1; write addr0=0xE4 (control=1, reload 100), addr2=0x0A, addr3=0xB0 (LUT[22]=96, timer hi 0); pulse `quarter_frame` → `linear`=100 and `length_active`=1. `wave` then steps 15,14,… every 11 clks, reaches 0,0 then 1..15, and wraps to 15 after 32 steps.
- **Length countdown:**
  - With control=1, 200 `half_frame` pulses → `length_active` stays 1.
  - Write addr0=0x64 (control=0), then 96 `half_frame` pulses → `length_active`=0 and `wave` freezes at its current value.
- **Linear countdown:** control=0, reload 3; addr3 write, then 4 `quarter_frame` pulses → `linear` goes 3, 2, 1, 0, `wave` freezes, and `reload_flag` is clear. A further addr3 write plus one quarter pulse restarts stepping.
- **Ultrasonic:** addr2=0x01, hi=0 → `wave` holds indefinitely. addr2=0x02 → stepping every 3 clks.
- **Enable/collision:**
  - Drop `enable` mid-tone → `length_active`=0 the next cycle and `wave` holds.
  - addr3 write coincident with `half_frame` → `length` equals the LUT value, not LUT−1.

Source files
------------

// File: rtl/triangle_channel_gen.sv
// NES-style triangle channel: linear counter, length counter, period timer and a
// 2^(SEQ_BITS+1)-step up/down sequencer producing a SEQ_BITS-wide wave sample.
module triangle_channel_gen #(
  parameter int unsigned TIMER_WIDTH    = 11,
  parameter int unsigned SEQ_BITS       = 4,
  parameter int unsigned LINEAR_WIDTH   = 7,
  parameter int unsigned ULTRASONIC_MIN = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                reg_write,
  input  logic [1:0]          reg_addr,
  input  logic [7:0]          reg_data,
  input  logic                quarter_frame,
  input  logic                half_frame,
  input  logic                enable,
  output logic [SEQ_BITS-1:0] wave,
  output logic                length_active
);

  localparam logic [TIMER_WIDTH-1:0] UltraMin = TIMER_WIDTH'(ULTRASONIC_MIN);
  localparam logic [SEQ_BITS-1:0]    WaveMax  = {SEQ_BITS{1'b1}};

  logic [TIMER_WIDTH-1:0]  period_q, period_d;
  logic [TIMER_WIDTH-1:0]  timer_cnt_q, timer_cnt_d;
  logic [SEQ_BITS:0]       step_q, step_d;
  logic [SEQ_BITS-1:0]     wave_q, wave_d;
  logic [LINEAR_WIDTH-1:0] linear_q, linear_d;
  logic [LINEAR_WIDTH-1:0] reload_val_q, reload_val_d;
  logic [7:0]              length_q, length_d;
  logic                    control_q, control_d;
  logic                    reload_flag_q, reload_flag_d;
  logic                    length_active_q, length_active_d;

  logic wr_ctrl, wr_lo, wr_hi;
  logic tick, gate_open;

  function automatic logic [7:0] length_lut(input logic [4:0] idx);
    logic [7:0] val;
    unique case (idx)
      5'd0:  val = 8'd10;
      5'd1:  val = 8'd254;
      5'd2:  val = 8'd20;
      5'd3:  val = 8'd2;
      5'd4:  val = 8'd40;
      5'd5:  val = 8'd4;
      5'd6:  val = 8'd80;
      5'd7:  val = 8'd6;
      5'd8:  val = 8'd160;
      5'd9:  val = 8'd8;
      5'd10: val = 8'd60;
      5'd11: val = 8'd10;
      5'd12: val = 8'd14;
      5'd13: val = 8'd12;
      5'd14: val = 8'd26;
      5'd15: val = 8'd14;
      5'd16: val = 8'd12;
      5'd17: val = 8'd16;
      5'd18: val = 8'd24;
      5'd19: val = 8'd18;
      5'd20: val = 8'd48;
      5'd21: val = 8'd20;
      5'd22: val = 8'd96;
      5'd23: val = 8'd22;
      5'd24: val = 8'd192;
      5'd25: val = 8'd24;
      5'd26: val = 8'd72;
      5'd27: val = 8'd26;
      5'd28: val = 8'd16;
      5'd29: val = 8'd28;
      5'd30: val = 8'd32;
      default: val = 8'd30;
    endcase
    return val;
  endfunction

  // First half of the sequence counts down from WaveMax, second half counts up.
  function automatic logic [SEQ_BITS-1:0] step_to_wave(input logic [SEQ_BITS:0] s);
    return s[SEQ_BITS] ? s[SEQ_BITS-1:0] : ~s[SEQ_BITS-1:0];
  endfunction

  always_comb begin
    wr_ctrl   = reg_write && (reg_addr == 2'd0);
    wr_lo     = reg_write && (reg_addr == 2'd2);
    wr_hi     = reg_write && (reg_addr == 2'd3);
    tick      = (timer_cnt_q == '0);
    gate_open = (linear_q != '0) && (length_q != 8'd0) && (period_q >= UltraMin);
  end

  // Register file and period timer.
  always_comb begin
    control_d    = control_q;
    reload_val_d = reload_val_q;
    period_d     = period_q;
    if (wr_ctrl) begin
      control_d    = reg_data[7];
      reload_val_d = reg_data[LINEAR_WIDTH-1:0];
    end
    if (wr_lo) begin
      period_d[7:0] = reg_data;
    end
    if (wr_hi) begin
      period_d[TIMER_WIDTH-1:8] = reg_data[TIMER_WIDTH-9:0];
    end

    if (wr_hi) begin
      timer_cnt_d = period_d;
    end else if (tick) begin
      timer_cnt_d = period_q;
    end else begin
      timer_cnt_d = timer_cnt_q - 1'b1;
    end
  end

  // Sequencer: holds its position whenever any gate is closed.
  always_comb begin
    step_d = step_q;
    if (tick && gate_open) begin
      step_d = step_q + 1'b1;
    end
    wave_d = step_to_wave(step_d);
  end

  // Linear counter; strobes see the pre-write control/reload_val/reload_flag.
  always_comb begin
    linear_d      = linear_q;
    reload_flag_d = reload_flag_q;
    if (quarter_frame) begin
      if (reload_flag_q) begin
        linear_d = reload_val_q;
      end else if (linear_q != '0) begin
        linear_d = linear_q - 1'b1;
      end
      if (!control_q) begin
        reload_flag_d = 1'b0;
      end
    end
    if (wr_hi) begin
      reload_flag_d = 1'b1;
    end
  end

  // Length counter; a load takes priority over a coincident half-frame decrement.
  always_comb begin
    length_d = length_q;
    if (!enable) begin
      length_d = 8'd0;
    end else if (wr_hi) begin
      length_d = length_lut(reg_data[7:3]);
    end else if (half_frame && !control_q && (length_q != 8'd0)) begin
      length_d = length_q - 8'd1;
    end
    length_active_d = (length_q != 8'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      period_q        <= '0;
      timer_cnt_q     <= '0;
      step_q          <= '0;
      wave_q          <= WaveMax;
      linear_q        <= '0;
      reload_val_q    <= '0;
      length_q        <= 8'd0;
      control_q       <= 1'b0;
      reload_flag_q   <= 1'b0;
      length_active_q <= 1'b0;
    end else begin
      period_q        <= period_d;
      timer_cnt_q     <= timer_cnt_d;
      step_q          <= step_d;
      wave_q          <= wave_d;
      linear_q        <= linear_d;
      reload_val_q    <= reload_val_d;
      length_q        <= length_d;
      control_q       <= control_d;
      reload_flag_q   <= reload_flag_d;
      length_active_q <= length_active_d;
    end
  end

  assign wave          = wave_q;
  assign length_active = length_active_q;

endmodule
